ex_redirect_ctrl: RTL and testbench

- Sequences the pipeline flush and front-end redirect when the write-back stage reports an exception (wb_ex) or an exception return (eret_flush).
- Tracks outstanding instruction-fetch requests, blocks new fetches during a flush, and discards stale responses until the bus is drained.
- Issues exactly one redirect (exception entry or ERA) to IF through a valid/ready handshake.
- Sits between WB/CSR and the IF stage.

---
 rtl/ex_redirect_ctrl.sv | 124 ++++++++++++
 tb/tb_ex_redirect_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ex_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ex_redirect_ctrl
// Description : Flush/redirect sequencer for exceptions (wb_ex) and exception
//               returns (eret_flush) reported by write-back.
//               - Counts outstanding IF bus requests and gates new ones.
//               - On an event, flushes the pipeline, drains (and marks as
//                 stale) any in-flight IF responses, then hands exactly one
//                 redirect (exception entry or ERA) to IF via valid/ready.
// Ports       : clk, reset (async, active-high)
//               wb_ex, eret_flush, csr_eentry, csr_era   <- WB / CSR
//               req_issue, resp_done                     <- IF bus activity
//               req_allow, discard_resp                  -> IF fetch control
//               flush                                    -> IF/ID/EX/MEM
//               redirect_valid, redirect_pc, redirect_ready  <-> IF
//               busy, ex_cnt                             -> status
// Revision    : 1.0 - initial release
// ============================================================================
module ex_redirect_ctrl #(
    parameter int MAX_OUTST = 3,
    parameter int OUTST_W   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_ex,
    input  logic        eret_flush,
    input  logic [31:0] csr_eentry,
    input  logic [31:0] csr_era,
    input  logic        req_issue,
    input  logic        resp_done,
    output logic        req_allow,
    output logic        discard_resp,
    output logic        flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        busy,
    output logic [31:0] ex_cnt
);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_DRAIN    = 2'd1;
    localparam logic [1:0] S_REDIRECT = 2'd2;

    localparam logic [OUTST_W-1:0] c_max_outst = OUTST_W'(MAX_OUTST);
    localparam logic [OUTST_W-1:0] c_one       = OUTST_W'(1);

    logic [1:0]         r_state;
    logic [OUTST_W-1:0] r_outst;
    logic [OUTST_W-1:0] w_outst_next;
    logic [31:0]        r_target;
    logic [31:0]        r_ex_cnt;

    logic w_idle;
    logic w_event;
    logic w_issue;
    logic w_resp;

    assign w_idle  = (r_state == S_IDLE);
    // Events are only sampled in IDLE; anything arriving mid-sequence is dropped.
    assign w_event = w_idle & (wb_ex | eret_flush);

    assign req_allow = w_idle && (r_outst < c_max_outst);

    // An issue the bus should never have accepted (req_allow low) does not
    // count, and a response with nothing outstanding cannot underflow.
    assign w_issue = req_issue & req_allow;
    assign w_resp  = resp_done & (r_outst != '0);

    always_comb begin
        w_outst_next = r_outst;
        if (w_issue && !w_resp) begin
            w_outst_next = r_outst + c_one;
        end else if (!w_issue && w_resp) begin
            w_outst_next = r_outst - c_one;
        end
    end

    // flush is combinational so it reaches the pipeline in the event cycle.
    assign flush          = ~w_idle | w_event;
    assign discard_resp   = (r_state == S_DRAIN) & resp_done;
    assign redirect_valid = (r_state == S_REDIRECT);
    assign redirect_pc    = r_target;
    assign busy           = ~w_idle;
    assign ex_cnt         = r_ex_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_outst  <= '0;
            r_target <= '0;
            r_ex_cnt <= '0;
        end else begin
            r_outst <= w_outst_next;
            case (r_state)
                S_IDLE: begin
                    if (w_event) begin
                        // wb_ex has priority over a simultaneous eret_flush.
                        r_target <= wb_ex ? csr_eentry : csr_era;
                        if (wb_ex) begin
                            r_ex_cnt <= r_ex_cnt + 32'd1;
                        end
                        r_state <= (w_outst_next != '0) ? S_DRAIN : S_REDIRECT;
                    end
                end
                S_DRAIN: begin
                    if (w_outst_next == '0) begin
                        r_state <= S_REDIRECT;
                    end
                end
                S_REDIRECT: begin
                    if (redirect_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_redirect_ctrl
// Description : Self-checking bench for ex_redirect_ctrl. A per-cycle vector
//               table drives inputs and holds hand-computed outputs; the
//               asynchronous reset case is a hand-written sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_redirect_ctrl;

    localparam logic [31:0] c_ee = 32'h1C00_8000;
    localparam logic [31:0] c_er = 32'h1C00_0044;

    logic        clk;
    logic        reset;
    logic        wb_ex;
    logic        eret_flush;
    logic [31:0] csr_eentry;
    logic [31:0] csr_era;
    logic        req_issue;
    logic        resp_done;
    logic        req_allow;
    logic        discard_resp;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        busy;
    logic [31:0] ex_cnt;

    int n_chk;
    int n_fail;

    ex_redirect_ctrl #(.MAX_OUTST(3), .OUTST_W(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .wb_ex          (wb_ex),
        .eret_flush     (eret_flush),
        .csr_eentry     (csr_eentry),
        .csr_era        (csr_era),
        .req_issue      (req_issue),
        .resp_done      (resp_done),
        .req_allow      (req_allow),
        .discard_resp   (discard_resp),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .busy           (busy),
        .ex_cnt         (ex_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One record per clock cycle: inputs for the cycle and the outputs
    // expected while those inputs are applied.
    typedef struct {
        logic        wbx;
        logic        ert;
        logic        iss;
        logic        rsp;
        logic        rdy;
        logic [31:0] een;
        logic [31:0] era;
        logic [4:0]  ctl;   // {req_allow, discard_resp, flush, redirect_valid, busy}
        logic        pc_chk;
        logic [31:0] pc;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic wbx, ert, iss, rsp, rdy,
                       input logic [31:0] een, era_v,
                       input logic [4:0] ctl,
                       input logic pc_chk,
                       input logic [31:0] pc, cnt);
        vec_t v;
        v.wbx = wbx; v.ert = ert; v.iss = iss; v.rsp = rsp; v.rdy = rdy;
        v.een = een; v.era = era_v; v.ctl = ctl;
        v.pc_chk = pc_chk; v.pc = pc; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int row,
                       input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (row %0d): got %h, expected %h", name, row, act, exp);
        end
    endtask

    function automatic logic [4:0] ctl_now();
        return {req_allow, discard_resp, flush, redirect_valid, busy};
    endfunction

    task automatic drive_idle();
        wb_ex = 1'b0; eret_flush = 1'b0; req_issue = 1'b0;
        resp_done = 1'b0; redirect_ready = 1'b0;
        csr_eentry = c_ee; csr_era = c_er;
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b1;
        drive_idle();

        // ctl codes: IDLE 10000, IDLE+event 10100, IDLE full 00000,
        //            DRAIN 00101, DRAIN+resp 01101, REDIRECT 00111
        // Exception with nothing outstanding.
        add(1,0,0,0,1, c_ee,c_er, 5'b10100, 1, 32'h0, 0);
        add(0,0,0,0,1, c_ee,c_er, 5'b00111, 1, c_ee, 1);
        add(0,0,0,0,0, c_ee,c_er, 5'b10000, 1, c_ee, 1);
        // Two requests outstanding, then eret: drain and discard both.
        add(0,0,1,0,0, c_ee,c_er, 5'b10000, 1, c_ee, 1);
        add(0,0,1,0,0, c_ee,c_er, 5'b10000, 1, c_ee, 1);
        add(0,1,0,0,0, c_ee,c_er, 5'b10100, 1, c_ee, 1);
        add(0,0,0,0,0, c_ee,c_er, 5'b00101, 0, 32'h0, 1);
        add(0,0,0,1,0, c_ee,c_er, 5'b01101, 0, 32'h0, 1);
        add(0,0,0,1,0, c_ee,c_er, 5'b01101, 0, 32'h0, 1);
        add(0,0,0,0,1, c_ee,c_er, 5'b00111, 1, c_er, 1);
        add(0,0,0,0,0, c_ee,c_er, 5'b10000, 1, c_er, 1);
        // Both events together: wb_ex wins.
        add(1,1,0,0,0, c_ee,c_er, 5'b10100, 1, c_er, 1);
        // Stalled redirect: CSR inputs change and events pulse, no re-latch.
        add(0,0,0,0,0, 32'hDEAD_0000,32'hBEEF_0000, 5'b00111, 1, c_ee, 2);
        add(1,0,0,0,0, 32'h1111_1111,32'h2222_2222, 5'b00111, 1, c_ee, 2);
        add(0,1,0,0,0, 32'hDEAD_0000,32'hBEEF_0000, 5'b00111, 1, c_ee, 2);
        add(1,1,0,0,0, 32'h1111_1111,32'h2222_2222, 5'b00111, 1, c_ee, 2);
        add(0,0,0,0,0, 32'hDEAD_0000,32'hBEEF_0000, 5'b00111, 1, c_ee, 2);
        add(0,0,0,0,1, c_ee,c_er, 5'b00111, 1, c_ee, 2);
        add(0,0,0,0,0, c_ee,c_er, 5'b10000, 1, c_ee, 2);
        // Outstanding limit: fill to 3, illegal 4th issue, issue+resp.
        add(0,0,1,0,0, c_ee,c_er, 5'b10000, 1, c_ee, 2);
        add(0,0,1,0,0, c_ee,c_er, 5'b10000, 1, c_ee, 2);
        add(0,0,1,0,0, c_ee,c_er, 5'b10000, 1, c_ee, 2);
        add(0,0,1,0,0, c_ee,c_er, 5'b00000, 1, c_ee, 2);
        add(0,0,0,1,0, c_ee,c_er, 5'b00000, 1, c_ee, 2);
        add(0,0,1,1,0, c_ee,c_er, 5'b10000, 1, c_ee, 2);
        add(0,0,1,0,0, c_ee,c_er, 5'b10000, 1, c_ee, 2);
        add(0,0,0,0,0, c_ee,c_er, 5'b00000, 1, c_ee, 2);
        add(0,0,0,1,0, c_ee,c_er, 5'b00000, 1, c_ee, 2);
        // Exception with 2 outstanding: enter DRAIN (reset will cut it short).
        add(1,0,0,0,0, c_ee,c_er, 5'b10100, 1, c_ee, 2);
        add(0,0,0,0,1, c_ee,c_er, 5'b00101, 0, 32'h0, 3);

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_ctl", -1, {27'd0, ctl_now()}, {27'd0, 5'b10000});
        chk("reset_pc",  -1, redirect_pc, 32'h0);
        chk("reset_cnt", -1, ex_cnt, 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            wb_ex          = vecs[i].wbx;
            eret_flush     = vecs[i].ert;
            req_issue      = vecs[i].iss;
            resp_done      = vecs[i].rsp;
            redirect_ready = vecs[i].rdy;
            csr_eentry     = vecs[i].een;
            csr_era        = vecs[i].era;
            #1;
            chk("ctl", i, {27'd0, ctl_now()}, {27'd0, vecs[i].ctl});
            chk("ex_cnt", i, ex_cnt, vecs[i].cnt);
            if (vecs[i].pc_chk) begin
                chk("redirect_pc", i, redirect_pc, vecs[i].pc);
            end
        end

        // Asynchronous reset mid-DRAIN, well before the next rising edge.
        #1;
        reset = 1'b1;
        #1;
        chk("async_rst_ctl", 100, {27'd0, ctl_now()}, {27'd0, 5'b10000});
        chk("async_rst_pc",  100, redirect_pc, 32'h0);
        chk("async_rst_cnt", 100, ex_cnt, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        drive_idle();
        redirect_ready = 1'b1;
        // Abandoned sequence must never produce a redirect; a response with
        // nothing outstanding must not underflow the counter.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            resp_done = (k == 0);
            #1;
            chk("post_rst_ctl", 101 + k, {27'd0, ctl_now()}, {27'd0, 5'b10000});
        end
        // Exactly three issues fit after the ignored response.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            resp_done = 1'b0;
            req_issue = 1'b1;
            #1;
            chk("post_rst_allow", 105 + k, {31'd0, req_allow}, {31'd0, (k < 3)});
        end
        @(negedge clk);
        drive_idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
